// File: rtl/dbus_pkg.sv
// Shared constants and types for the riscv_dbus data-side bus.
// Includes the TIMECMP offset used only when DBUS_TIMER_IRQ_EN is defined.
package dbus_pkg;

  localparam int IO_BIT = 31;

  localparam logic [2:0] IO_LED     = 3'd0;
  localparam logic [2:0] IO_CYCLE   = 3'd1;
  localparam logic [2:0] IO_TXDATA  = 3'd2;
  localparam logic [2:0] IO_STATUS  = 3'd3;
  localparam logic [2:0] IO_TIMECMP = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: START, 8 data bits LSB first, STOP, each CLKS_PER_BIT cycles.
// tx is registered from the next state so the start bit appears at the accepting edge.
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  import dbus_pkg::*;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          baud_done;

  assign baud_done = (cnt_q == CNT_LAST);

  // Next-state, baud counter, bit index and next line level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          cnt_d   = CW'(0);
          data_d  = data;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          cnt_d   = CW'(0);
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          cnt_d = CW'(0);
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          state_d = IDLE;
          cnt_d   = CW'(0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CW'(0);
      bit_q   <= 3'd0;
      data_q  <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: rtl/riscv_dbus.sv
// Data-side RAM/MMIO unit: word RAM, LED, CYCLE counter, UART TX, optional timer compare.
// Define DBUS_TIMER_IRQ_EN to add the TIMECMP register and the sticky timer_irq flag.
module riscv_dbus #(
  parameter int DMEM_AW      = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic [7:0]  led,
  output logic        uart_tx,
  output logic        timer_irq
);
  import dbus_pkg::*;

  logic [31:0]        mem [0:(2**DMEM_AW)-1];
  logic [DMEM_AW-1:0] ram_idx;
  logic               io_sel;
  logic [2:0]         io_off;
  logic               io_wr;
  logic               tx_start;
  logic               uart_busy;
  logic [7:0]         led_q, led_d;
  logic [31:0]        cycle_q, cycle_d;
  logic [31:0]        rd_data;
  logic               unused_addr;

  assign ram_idx     = ALUResultM[DMEM_AW+1:2];
  assign io_sel      = ALUResultM[IO_BIT];
  assign io_off      = ALUResultM[4:2];
  assign io_wr       = MemWriteM && io_sel;
  assign tx_start    = io_wr && (io_off == IO_TXDATA);
  assign unused_addr = ^{ALUResultM[30:DMEM_AW+2], ALUResultM[1:0]};

`ifdef DBUS_TIMER_IRQ_EN
  logic [31:0] timecmp_q, timecmp_d;
  logic        timer_irq_q, timer_irq_d;

  // TIMECMP load and sticky compare flag; a TIMECMP write beats a same-cycle match
  always_comb begin
    if (io_wr && (io_off == IO_TIMECMP)) begin
      timecmp_d   = WriteDataM;
      timer_irq_d = 1'b0;
    end else if (cycle_q == timecmp_q) begin
      timecmp_d   = timecmp_q;
      timer_irq_d = 1'b1;
    end else begin
      timecmp_d   = timecmp_q;
      timer_irq_d = timer_irq_q;
    end
  end

  // Timer compare registers
  always_ff @(posedge clk) begin
    if (reset) begin
      timecmp_q   <= 32'hFFFF_FFFF;
      timer_irq_q <= 1'b0;
    end else begin
      timecmp_q   <= timecmp_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  assign timer_irq = timer_irq_q;
`else
  assign timer_irq = 1'b0;
`endif

  // Zero-wait-state load mux, independent of MemWriteM
  always_comb begin
    rd_data = 32'h0000_0000;
    if (!io_sel) begin
      rd_data = mem[ram_idx];
    end else begin
      case (io_off)
        IO_LED:     rd_data = {24'h00_0000, led_q};
        IO_CYCLE:   rd_data = cycle_q;
        IO_STATUS:  rd_data = {31'h0000_0000, uart_busy};
`ifdef DBUS_TIMER_IRQ_EN
        IO_TIMECMP: rd_data = timecmp_q;
`endif
        default:    rd_data = 32'h0000_0000;
      endcase
    end
  end

  // LED and CYCLE next values; a CYCLE write overrides the increment
  always_comb begin
    if (io_wr && (io_off == IO_LED)) begin
      led_d = WriteDataM[7:0];
    end else begin
      led_d = led_q;
    end
    if (io_wr && (io_off == IO_CYCLE)) begin
      cycle_d = WriteDataM;
    end else begin
      cycle_d = cycle_q + 32'd1;
    end
  end

  // LED and CYCLE registers
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q   <= 8'h00;
      cycle_q <= 32'h0000_0000;
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_d;
    end
  end

  // Data RAM: synchronous write, contents survive reset
  always_ff @(posedge clk) begin
    if (MemWriteM && !io_sel) begin
      mem[ram_idx] <= WriteDataM;
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .reset(reset),
    .start(tx_start),
    .data (WriteDataM[7:0]),
    .tx   (uart_tx),
    .busy (uart_busy)
  );

  assign ReadDataM = rd_data;
  assign led       = led_q;

endmodule

// File: tb/tb_riscv_dbus.sv
// Self-checking bench for riscv_dbus: directed steps followed by random traffic,
// compared every cycle against a cycle-indexed behavioural model.
module tb_riscv_dbus;

  localparam int CPB = 4;
  localparam int AW  = 8;
  localparam logic [31:0] A_LED     = 32'h8000_0000;
  localparam logic [31:0] A_CYCLE   = 32'h8000_0004;
  localparam logic [31:0] A_TXDATA  = 32'h8000_0008;
  localparam logic [31:0] A_STATUS  = 32'h8000_000C;
  localparam logic [31:0] A_TIMECMP = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic [7:0]  led;
  logic        uart_tx;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  // Model state: values visible during cycle n (between edges n and n+1)
  int          n      = 0;
  logic        mvalid = 1'b0;
  logic [31:0] ram_m [int];
  logic [7:0]  m_led;
  logic [31:0] m_cyc;
  logic [31:0] m_tc;
  logic        m_irq;
  logic        fv;
  int          fs;
  logic [7:0]  fbyte;

  riscv_dbus #(.DMEM_AW(AW), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWriteM (MemWriteM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .ReadDataM (ReadDataM),
    .led       (led),
    .uart_tx   (uart_tx),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_busy();
    return fv && ((n - fs) < 10 * CPB);
  endfunction

  function automatic logic m_tx();
    logic [9:0] fr;
    if (!m_busy()) return 1'b1;
    fr = {1'b1, fbyte, 1'b0};
    return fr[(n - fs) / CPB];
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    if (!a[31]) return ram_m[int'(a[AW+1:2])];
    case (a[4:2])
      3'd0:    return {24'h0, m_led};
      3'd1:    return m_cyc;
      3'd3:    return {31'h0, m_busy()};
`ifdef DBUS_TIMER_IRQ_EN
      3'd4:    return m_tc;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Apply inputs, move to the falling edge and compare all outputs to the model
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rst);
    MemWriteM  = we;
    ALUResultM = a;
    WriteDataM = wd;
    reset      = rst;
    @(negedge clk);
    if (mvalid) begin
      chk("uart_tx", {31'h0, uart_tx}, {31'h0, m_tx()});
      chk("led", {24'h0, led}, {24'h0, m_led});
`ifdef DBUS_TIMER_IRQ_EN
      chk("timer_irq", {31'h0, timer_irq}, {31'h0, m_irq});
`else
      chk("timer_irq", {31'h0, timer_irq}, 32'h0);
`endif
      if (a[31] || ram_m.exists(int'(a[AW+1:2])))
        chk("rd", ReadDataM, m_rd(a));
    end
  endtask

  // Advance one clock edge and apply the architectural update rules to the model
  task automatic tick();
    logic [31:0] a;
    logic        w;
    @(posedge clk);
    a = ALUResultM;
    w = MemWriteM;
    if (w && !a[31]) ram_m[int'(a[AW+1:2])] = WriteDataM;
    if (reset) begin
      m_led = 8'h00; m_cyc = 32'h0; m_tc = 32'hFFFF_FFFF; m_irq = 1'b0; fv = 1'b0;
      mvalid = 1'b1;
    end else begin
      if (w && a[31] && a[4:2] == 3'd2 && !m_busy()) begin
        fv = 1'b1; fs = n + 1; fbyte = WriteDataM[7:0];
      end
      if (w && a[31] && a[4:2] == 3'd4) m_irq = 1'b0;
      else if (m_cyc == m_tc) m_irq = 1'b1;
`ifdef DBUS_TIMER_IRQ_EN
      if (w && a[31] && a[4:2] == 3'd4) m_tc = WriteDataM;
`endif
      if (w && a[31] && a[4:2] == 3'd0) m_led = WriteDataM[7:0];
      if (w && a[31] && a[4:2] == 3'd1) m_cyc = WriteDataM;
      else m_cyc = m_cyc + 32'd1;
    end
    n++;
    #1;
  endtask

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rst);
    drive(we, a, wd, rst);
    tick();
  endtask

  initial begin
    logic [9:0]  fr;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic        rst;
    int          r;

    MemWriteM = 1'b0; ALUResultM = 32'h0; WriteDataM = 32'h0; reset = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1);

    // RAM write, read-back and aliasing
    step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    drive(1'b0, 32'h0000_0010, 32'h0, 1'b0);
    chk("ram_read", ReadDataM, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 32'h0000_0410, 32'h0, 1'b0);
    chk("ram_alias", ReadDataM, 32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 16; i++) step(1'b1, 32'(i * 4), $urandom, 1'b0);

    // LED write and reset
    step(1'b1, A_LED, 32'h0000_01A5, 1'b0);
    drive(1'b0, A_LED, 32'h0, 1'b0);
    chk("led_val", {24'h0, led}, 32'h0000_00A5);
    chk("led_read", ReadDataM, 32'h0000_00A5);
    tick();
    step(1'b0, A_LED, 32'h0, 1'b1);
    drive(1'b0, A_LED, 32'h0, 1'b0);
    chk("led_reset", {24'h0, led}, 32'h0);
    tick();

    // CYCLE count after reset, load and wrap
    step(1'b0, A_CYCLE, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, A_CYCLE, 32'h0, 1'b0);
    drive(1'b0, A_CYCLE, 32'h0, 1'b0);
    chk("cycle_10", ReadDataM, 32'd10);
    tick();
    step(1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0);
    drive(1'b0, A_CYCLE, 32'h0, 1'b0); chk("cycle_fe", ReadDataM, 32'hFFFF_FFFE); tick();
    drive(1'b0, A_CYCLE, 32'h0, 1'b0); chk("cycle_ff", ReadDataM, 32'hFFFF_FFFF); tick();
    drive(1'b0, A_CYCLE, 32'h0, 1'b0); chk("cycle_wrap", ReadDataM, 32'h0); tick();

    // UART frame of 0x55 with a dropped second write
    step(1'b1, A_TXDATA, 32'h55, 1'b0);
    for (int k = 0; k < 45; k++) begin
      if (k == 5) drive(1'b1, A_TXDATA, 32'h77, 1'b0);
      else drive(1'b0, A_STATUS, 32'h0, 1'b0);
      chk("tx_wave", {31'h0, uart_tx}, (k < 40) ? 32'((k / 4) % 2) : 32'd1);
      if (k != 5) chk("status", ReadDataM, (k < 40) ? 32'd1 : 32'd0);
      tick();
    end

    // Reset mid-frame, then a clean frame
    step(1'b1, A_TXDATA, 32'hA3, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, A_STATUS, 32'h0, 1'b0);
    step(1'b0, A_STATUS, 32'h0, 1'b1);
    drive(1'b0, A_STATUS, 32'h0, 1'b0);
    chk("tx_after_rst", {31'h0, uart_tx}, 32'd1);
    chk("status_after_rst", ReadDataM, 32'd0);
    tick();
    step(1'b1, A_TXDATA, 32'h3C, 1'b0);
    fr = {1'b1, 8'h3C, 1'b0};
    for (int k = 0; k < 42; k++) begin
      drive(1'b0, A_STATUS, 32'h0, 1'b0);
      chk("tx_clean", {31'h0, uart_tx}, (k < 40) ? {31'h0, fr[k / 4]} : 32'd1);
      tick();
    end

    // Timer compare
`ifdef DBUS_TIMER_IRQ_EN
    step(1'b1, A_TIMECMP, 32'd20, 1'b0);
    step(1'b1, A_CYCLE, 32'd0, 1'b0);
    for (int k = 0; k < 26; k++) begin
      drive(1'b0, A_CYCLE, 32'h0, 1'b0);
      chk("cmp_cycle", ReadDataM, 32'(k));
      chk("cmp_irq", {31'h0, timer_irq}, (k >= 21) ? 32'd1 : 32'd0);
      tick();
    end
    step(1'b1, A_TIMECMP, 32'd1000, 1'b0);
    drive(1'b0, A_TIMECMP, 32'h0, 1'b0);
    chk("irq_clear", {31'h0, timer_irq}, 32'd0);
    chk("timecmp_read", ReadDataM, 32'd1000);
    tick();
`else
    for (int k = 0; k < 4; k++) step(1'b1, A_TIMECMP, 32'd0, 1'b0);
    drive(1'b0, A_TIMECMP, 32'h0, 1'b0);
    chk("no_timecmp", ReadDataM, 32'h0);
    chk("no_irq", {31'h0, timer_irq}, 32'h0);
    tick();
`endif

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      r  = int'($urandom_range(0, 9));
      wd = $urandom;
      if (r < 4) a = {1'b0, 21'($urandom), 8'($urandom_range(0, 15)), 2'($urandom)};
      else if (r < 6) a = {1'b1, 26'($urandom), 3'd2, 2'($urandom)};
      else a = {1'b1, 26'($urandom), 3'($urandom_range(0, 7)), 2'($urandom)};
      we = ($urandom_range(0, 2) == 0);
      if (we && a[31] && a[4:2] == 3'd4) wd = m_cyc + 32'($urandom_range(1, 30));
      rst = ($urandom_range(0, 199) == 0);
      if (rst) we = 1'b0;
      step(we, a, wd, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
